// File: rtl/modulo_alimentador_rolhas_pkg.sv
// Plant constants, buffer widths and FSM state encoding for the cork-feed controller.
package modulo_alimentador_rolhas_pkg;

  localparam int unsigned DEF_MAIN_CAP   = 20;
  localparam int unsigned DEF_MAIN_MIN   = 5;
  localparam int unsigned DEF_SEC_MAX    = 99;
  localparam int unsigned DEF_XFER_BATCH = 15;

  localparam int unsigned MAIN_W = 5;
  localparam int unsigned SEC_W  = 7;
  localparam int unsigned SUM_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/modulo_alimentador_rolhas_if.sv
// Operator/sealer-facing signal bundle of the cork-feed controller.
interface modulo_alimentador_rolhas_if;
  import modulo_alimentador_rolhas_pkg::*;

  logic              enable_i;
  logic              seal_pulse_i;
  logic              load_valid_i;
  logic [SEC_W-1:0]  load_qty_i;
  logic              load_accept_o;
  logic              load_reject_o;
  logic [MAIN_W-1:0] main_count_o;
  logic [SEC_W-1:0]  sec_count_o;
  logic              ro_o;
  logic              xfer_busy_o;
  logic              underflow_o;
  logic [1:0]        state_o;

  modport master (
    output enable_i, seal_pulse_i, load_valid_i, load_qty_i,
    input  load_accept_o, load_reject_o, main_count_o, sec_count_o,
           ro_o, xfer_busy_o, underflow_o, state_o
  );

  modport slave (
    input  enable_i, seal_pulse_i, load_valid_i, load_qty_i,
    output load_accept_o, load_reject_o, main_count_o, sec_count_o,
           ro_o, xfer_busy_o, underflow_o, state_o
  );

endinterface

// File: rtl/modulo_verificador_carga_rolhas.sv
// Load admission check: adds the offered corks to the post-transfer secondary
// count in 8 bits so a 7-bit overflow cannot hide an over-limit load.
module modulo_verificador_carga_rolhas
  import modulo_alimentador_rolhas_pkg::*;
#(
  parameter int unsigned SEC_MAX = DEF_SEC_MAX
) (
  input  logic [SEC_W-1:0] sec_after_i,
  input  logic [SEC_W-1:0] load_qty_i,
  output logic             accept_o,
  output logic [SEC_W-1:0] sec_sum_o
);

  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(SEC_MAX);

  logic [SUM_W-1:0] sum;

  // Widen, add and compare against the display limit
  always_comb begin
    sum       = {1'b0, sec_after_i} + {1'b0, load_qty_i};
    accept_o  = (sum <= LIMIT);
    sec_sum_o = sum[SEC_W-1:0];
  end

endmodule

// File: rtl/modulo_alimentador_rolhas.sv
// Cork-feed controller: main buffer feeds the sealer, secondary buffer holds
// operator-loaded reserve and refills the main buffer one cork per clock.
module modulo_alimentador_rolhas
  import modulo_alimentador_rolhas_pkg::*;
#(
  parameter int unsigned MAIN_CAP   = DEF_MAIN_CAP,
  parameter int unsigned MAIN_MIN   = DEF_MAIN_MIN,
  parameter int unsigned SEC_MAX    = DEF_SEC_MAX,
  parameter int unsigned XFER_BATCH = DEF_XFER_BATCH
) (
  input logic                        clk,
  input logic                        rst,
  modulo_alimentador_rolhas_if.slave bus
);

  localparam int unsigned        BATCH_W    = $clog2(XFER_BATCH + 1);
  localparam logic [MAIN_W-1:0]  MAIN_CAP_V = MAIN_W'(MAIN_CAP);
  localparam logic [MAIN_W-1:0]  MAIN_MIN_V = MAIN_W'(MAIN_MIN);
  localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(XFER_BATCH);

  state_t             state_q, state_d;
  logic [MAIN_W-1:0]  main_q, main_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [BATCH_W-1:0] batch_q, batch_d;
  logic               underflow_q, underflow_d;
  logic               accept_q, accept_d;
  logic               reject_q, reject_d;

  logic               move;
  logic               seal_act;
  logic               consume;
  logic [SEC_W-1:0]   sec_after;
  logic [SEC_W-1:0]   sec_sum;
  logic               load_ok;

  // This cycle's cork movements; kept apart from next-state so the load check sees a settled sec_after
  always_comb begin
    move      = bus.enable_i && (state_q == ST_XFER);
    seal_act  = bus.enable_i && (state_q != ST_HOLD) && bus.seal_pulse_i;
    consume   = seal_act && (main_q != '0);
    sec_after = sec_q - SEC_W'(move);
  end

  modulo_verificador_carga_rolhas #(
    .SEC_MAX (SEC_MAX)
  ) u_verificador (
    .sec_after_i (sec_after),
    .load_qty_i  (bus.load_qty_i),
    .accept_o    (load_ok),
    .sec_sum_o   (sec_sum)
  );

  // Next-state: FSM transitions, buffer counts, load decision and sticky underflow
  always_comb begin
    state_d     = state_q;
    main_d      = main_q + MAIN_W'(move) - MAIN_W'(consume);
    sec_d       = sec_after;
    batch_d     = batch_q;
    underflow_d = underflow_q | (seal_act && (main_q == '0));
    accept_d    = bus.load_valid_i && load_ok;
    reject_d    = bus.load_valid_i && !load_ok;
    if (accept_d) begin
      sec_d = sec_sum;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.enable_i) begin
          state_d = ST_HOLD;
        end else if ((main_q < MAIN_MIN_V) && (sec_q != '0)) begin
          state_d = ST_XFER;
          batch_d = '0;
        end
      end
      ST_XFER: begin
        if (!bus.enable_i) begin
          state_d = ST_HOLD;
        end else begin
          batch_d = batch_q + 1'b1;
          if ((batch_d == BATCH_LAST) || (sec_after == '0) || (main_d == MAIN_CAP_V)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (bus.enable_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any burst in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      main_q      <= MAIN_CAP_V;
      sec_q       <= '0;
      batch_q     <= '0;
      underflow_q <= 1'b0;
      accept_q    <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      sec_q       <= sec_d;
      batch_q     <= batch_d;
      underflow_q <= underflow_d;
      accept_q    <= accept_d;
      reject_q    <= reject_d;
    end
  end

  assign bus.load_accept_o = accept_q;
  assign bus.load_reject_o = reject_q;
  assign bus.main_count_o  = main_q;
  assign bus.sec_count_o   = sec_q;
  assign bus.ro_o          = (main_q == '0);
  assign bus.xfer_busy_o   = (state_q == ST_XFER);
  assign bus.underflow_o   = underflow_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_modulo_alimentador_rolhas.sv
// Self-checking bench for the cork-feed controller: vector table, directed
// multi-cycle sequences and randomized traffic against a rule-level model.
module tb_modulo_alimentador_rolhas;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  modulo_alimentador_rolhas_if bus();

  modulo_alimentador_rolhas #(
    .MAIN_CAP   (20),
    .MAIN_MIN   (5),
    .SEC_MAX    (99),
    .XFER_BATCH (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model (buffer rules, not RTL structure) ----------------
  typedef enum {M_IDLE, M_REFILL, M_HOLD} mmode_t;
  mmode_t m_mode;
  int     m_main, m_sec, m_left;
  bit     m_under, m_acc, m_rej;

  function automatic void model_reset();
    m_mode = M_IDLE; m_main = 20; m_sec = 0; m_left = 0;
    m_under = 0; m_acc = 0; m_rej = 0;
  endfunction

  function automatic int mode_code(mmode_t m);
    if (m == M_REFILL) return 1;
    if (m == M_HOLD) return 2;
    return 0;
  endfunction

  function automatic void model_step(bit en, bit seal, bit lv, int qty);
    int     nmain;
    int     nsec;
    mmode_t nmode;
    bit     moved;
    bit     sealing;
    nmain = m_main; nsec = m_sec; nmode = m_mode; moved = 0;
    sealing = en && (m_mode != M_HOLD) && seal;
    if (!en) begin
      nmode = M_HOLD;
    end else begin
      case (m_mode)
        M_HOLD: nmode = M_IDLE;
        M_IDLE: if (m_main < 5 && m_sec > 0) begin nmode = M_REFILL; m_left = 15; end
        M_REFILL: begin moved = 1; nmain += 1; nsec -= 1; m_left -= 1; end
      endcase
    end
    if (sealing) begin
      if (m_main > 0) nmain -= 1;
      else m_under = 1;
    end
    if (moved && (m_left == 0 || nsec == 0 || nmain == 20)) nmode = M_IDLE;
    m_acc = 0; m_rej = 0;
    if (lv) begin
      if (nsec + qty <= 99) begin nsec += qty; m_acc = 1; end
      else m_rej = 1;
    end
    m_main = nmain; m_sec = nsec; m_mode = nmode;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int e_main, input int e_sec,
                               input int e_state, input int e_acc, input int e_rej,
                               input int e_under);
    chk({tag, ".main"},  int'(bus.main_count_o),  e_main);
    chk({tag, ".sec"},   int'(bus.sec_count_o),   e_sec);
    chk({tag, ".state"}, int'(bus.state_o),       e_state);
    chk({tag, ".acc"},   int'(bus.load_accept_o), e_acc);
    chk({tag, ".rej"},   int'(bus.load_reject_o), e_rej);
    chk({tag, ".under"}, int'(bus.underflow_o),   e_under);
    chk({tag, ".ro"},    int'(bus.ro_o),          (e_main == 0) ? 1 : 0);
    chk({tag, ".busy"},  int'(bus.xfer_busy_o),   (e_state == 1) ? 1 : 0);
  endtask

  task automatic cycle(input bit en, input bit seal, input bit lv, input int qty);
    bus.enable_i     = en;
    bus.seal_pulse_i = seal;
    bus.load_valid_i = lv;
    bus.load_qty_i   = 7'(qty);
    model_step(en, seal, lv, qty);
    @(posedge clk); #1;
    bus.seal_pulse_i = 1'b0;
    bus.load_valid_i = 1'b0;
    bus.load_qty_i   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enable_i = 1'b1; bus.seal_pulse_i = 1'b0;
    bus.load_valid_i = 1'b0; bus.load_qty_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Runs idle cycles while a burst is active; returns number of move cycles seen
  task automatic count_burst(output int n);
    n = 0;
    for (int i = 0; i < 40 && bus.xfer_busy_o; i++) begin
      cycle(1, 0, 0, 0);
      n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit en; bit seal; bit lv; int qty;
    int e_main; int e_sec; int e_state; int e_acc; int e_rej; int e_under;
  } vec_t;
  vec_t vt[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit en, seal, lv;
    int qty;
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.enable_i = 1'b1; bus.seal_pulse_i = 1'b0;
    bus.load_valid_i = 1'b0; bus.load_qty_i = '0;
    model_reset();

    //            en seal lv qty   main sec st acc rej und
    vt[0]  = '{1, 0, 0, 0,   20, 0,  0, 0, 0, 0};
    vt[1]  = '{1, 0, 1, 90,  20, 90, 0, 1, 0, 0};
    vt[2]  = '{1, 0, 1, 10,  20, 90, 0, 0, 1, 0};
    vt[3]  = '{1, 0, 1, 9,   20, 99, 0, 1, 0, 0};
    vt[4]  = '{1, 0, 0, 0,   20, 99, 0, 0, 0, 0};
    vt[5]  = '{1, 0, 1, 0,   20, 99, 0, 1, 0, 0};
    vt[6]  = '{1, 0, 1, 127, 20, 99, 0, 0, 1, 0};
    vt[7]  = '{1, 1, 0, 0,   19, 99, 0, 0, 0, 0};
    vt[8]  = '{0, 1, 0, 0,   19, 99, 2, 0, 0, 0};
    vt[9]  = '{0, 1, 0, 0,   19, 99, 2, 0, 0, 0};
    vt[10] = '{1, 1, 0, 0,   19, 99, 0, 0, 0, 0};
    vt[11] = '{1, 1, 0, 0,   18, 99, 0, 0, 0, 0};

    // Reset state
    do_reset();
    check_outputs("reset", 20, 0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      cycle(vt[i].en, vt[i].seal, vt[i].lv, vt[i].qty);
      check_outputs($sformatf("vec%0d", i), vt[i].e_main, vt[i].e_sec, vt[i].e_state,
                    vt[i].e_acc, vt[i].e_rej, vt[i].e_under);
    end

    // Full 15-cork burst from main=4
    do_reset();
    cycle(1, 0, 1, 50);
    check_outputs("s2.load", 20, 50, 0, 1, 0, 0);
    repeat (16) cycle(1, 1, 0, 0);
    check_outputs("s2.drain", 4, 50, 0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_outputs("s2.enter", 4, 50, 1, 0, 0, 0);
    count_burst(n);
    chk("s2.burst_len", n, 15);
    check_outputs("s2.end", 19, 35, 0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_outputs("s2.after", 19, 35, 0, 0, 0, 0);

    // Burst ends on empty secondary, then drain to empty and underflow
    do_reset();
    repeat (18) cycle(1, 1, 0, 0);
    check_outputs("s4.drain", 2, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 3);
    check_outputs("s4.load", 2, 3, 0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check_outputs("s4.enter", 2, 3, 1, 0, 0, 0);
    count_burst(n);
    chk("s4.burst_len", n, 3);
    check_outputs("s4.end", 5, 0, 0, 0, 0, 0);
    repeat (5) cycle(1, 1, 0, 0);
    check_outputs("s4.empty", 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    check_outputs("s4.underflow", 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    check_outputs("s4.sticky", 0, 0, 0, 0, 0, 1);

    // Seal and load landing on a transfer move
    do_reset();
    cycle(1, 0, 1, 50);
    repeat (16) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check_outputs("s5.enter", 4, 50, 1, 0, 0, 0);
    cycle(1, 1, 1, 5);
    check_outputs("s5.both", 4, 54, 1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check_outputs("s5.next", 5, 53, 1, 0, 0, 0);

    // Enable drop mid-burst, fresh burst afterwards, then async reset mid-burst
    do_reset();
    cycle(1, 0, 1, 50);
    repeat (16) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (6) cycle(1, 0, 0, 0);
    check_outputs("s6.six", 10, 44, 1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_outputs("s6.hold", 10, 44, 2, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0);
    check_outputs("s6.hold_seal", 10, 44, 2, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_outputs("s6.resume", 10, 44, 0, 0, 0, 0);
    repeat (6) cycle(1, 1, 0, 0);
    check_outputs("s6.drain", 4, 44, 0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_outputs("s6.enter2", 4, 44, 1, 0, 0, 0);
    count_burst(n);
    chk("s6.burst_len", n, 15);
    check_outputs("s6.end2", 19, 29, 0, 0, 0, 0);
    repeat (15) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_outputs("s6.mid", 6, 27, 1, 0, 0, 0);
    #3 rst = 1'b1;
    #1 check_outputs("s6.async_rst", 20, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 19) != 0);
      seal = ($urandom_range(0, 2) == 0);
      lv   = ($urandom_range(0, 5) == 0);
      qty  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 30));
      cycle(en, seal, lv, qty);
      check_outputs("rnd", m_main, m_sec, mode_code(m_mode), m_acc, m_rej, m_under);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
